// File: rtl/apb_led_pkg.sv
// Shared register map and control-bit positions for the APB PWM LED controller.
package apb_led_pkg;

    localparam logic [31:0] CTRL_OFS       = 32'h00;
    localparam logic [31:0] PRESCALE_OFS   = 32'h04;
    localparam logic [31:0] BLINK_PER_OFS  = 32'h08;
    localparam logic [31:0] BLINK_MASK_OFS = 32'h0C;
    localparam logic [31:0] STATUS_OFS     = 32'h10;
    localparam logic [31:0] DUTY_BASE      = 32'h20;

    localparam int CTRL_EN_BIT       = 0;
    localparam int CTRL_BLINK_EN_BIT = 1;

endpackage

// File: rtl/led_pwm_chan.sv
// One LED channel: duty shadow register that only reloads at period boundaries,
// followed by the registered compare-and-blank output stage.
module led_pwm_chan #(
    parameter int PWM_BITS = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load_i,
    input  logic                en_i,
    input  logic                blank_i,
    input  logic [PWM_BITS-1:0] duty_i,
    input  logic [PWM_BITS-1:0] pwm_cnt_i,
    output logic                led_o
);

    logic [PWM_BITS-1:0] shadow_q;
    logic                led_q;

    // The shadow keeps the running period's duty stable while software rewrites it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            shadow_q <= '0;
            led_q    <= 1'b0;
        end else begin
            if (load_i) begin
                shadow_q <= duty_i;
            end
            led_q <= en_i & (shadow_q > pwm_cnt_i) & ~blank_i;
        end
    end

    assign led_o = led_q;

endmodule

// File: rtl/apb_pwm_led_ctl.sv
// APB3 slave driving NUM_CH PWM LED channels with a shared, maskable blink.
// Holds the APB decode, register file, prescaler, PWM counter and blink counter.
module apb_pwm_led_ctl
    import apb_led_pkg::*;
#(
    parameter int NUM_CH     = 14,
    parameter int PWM_BITS   = 8,
    parameter int PRESC_BITS = 16,
    parameter int ADDR_W     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       paddr,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [31:0]       pwdata,
    output logic [31:0]       prdata,
    output logic              pready,
    output logic              pslverr,
    output logic [NUM_CH-1:0] led_out
);

    localparam logic [PWM_BITS-1:0] PWM_LAST = {{(PWM_BITS-1){1'b1}}, 1'b0};

    logic [1:0]            ctrl_q;
    logic [PRESC_BITS-1:0] presc_q;
    logic [15:0]           blinkPer_q;
    logic [NUM_CH-1:0]     blinkMask_q;
    logic [PWM_BITS-1:0]   duty_q [NUM_CH];
    logic [PWM_BITS-1:0]   dutyNext [NUM_CH];

    logic [PRESC_BITS-1:0] prescCnt_q, prescCnt_d;
    logic [PWM_BITS-1:0]   pwmCnt_q, pwmCnt_d;
    logic [15:0]           blinkCnt_q, blinkCnt_d;
    logic                  phase_q, phase_d;

    logic [31:0]       ofs, dutyRel;
    logic              isCtrl, isPresc, isBlinkPer, isBlinkMask, isStatus, isDuty;
    logic              addrOk, access, wrOk;
    logic [NUM_CH-1:0] dutySel;
    logic              en, blinkEn, tick, wrap;
    logic              unusedBits;

    assign ofs         = 32'({paddr[ADDR_W-1:2], 2'b00});
    assign dutyRel     = ofs - DUTY_BASE;
    assign isCtrl      = (ofs == CTRL_OFS);
    assign isPresc     = (ofs == PRESCALE_OFS);
    assign isBlinkPer  = (ofs == BLINK_PER_OFS);
    assign isBlinkMask = (ofs == BLINK_MASK_OFS);
    assign isStatus    = (ofs == STATUS_OFS);
    assign isDuty      = (ofs >= DUTY_BASE) && (dutyRel[31:2] < 30'(NUM_CH));
    assign addrOk      = isCtrl | isPresc | isBlinkPer | isBlinkMask | isStatus | isDuty;

    assign access  = psel & penable;
    assign pslverr = access & (~addrOk | (pwrite & isStatus));
    assign wrOk    = access & pwrite & addrOk & ~isStatus;
    assign pready  = 1'b1;

    assign en      = ctrl_q[CTRL_EN_BIT];
    assign blinkEn = ctrl_q[CTRL_BLINK_EN_BIT];
    assign tick    = en & (prescCnt_q >= presc_q);
    assign wrap    = tick & (pwmCnt_q == PWM_LAST);

    assign unusedBits = ^{paddr[31:ADDR_W], paddr[1:0], pwdata, dutyRel[1:0]};

    always_ff @(posedge clk) begin
        if (!rst) begin
            ctrl_q      <= '0;
            presc_q     <= '0;
            blinkPer_q  <= '0;
            blinkMask_q <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                duty_q[i] <= '0;
            end
        end else begin
            if (wrOk && isCtrl)      ctrl_q      <= pwdata[1:0];
            if (wrOk && isPresc)     presc_q     <= pwdata[PRESC_BITS-1:0];
            if (wrOk && isBlinkPer)  blinkPer_q  <= pwdata[15:0];
            if (wrOk && isBlinkMask) blinkMask_q <= pwdata[NUM_CH-1:0];
            for (int i = 0; i < NUM_CH; i++) begin
                if (wrOk && dutySel[i]) duty_q[i] <= pwdata[PWM_BITS-1:0];
            end
        end
    end

    // Unmapped and erroneous reads fall through to zero.
    always_comb begin
        prdata = '0;
        if (psel) begin
            if (isCtrl)      prdata[1:0]            = ctrl_q;
            if (isPresc)     prdata[PRESC_BITS-1:0] = presc_q;
            if (isBlinkPer)  prdata[15:0]           = blinkPer_q;
            if (isBlinkMask) prdata[NUM_CH-1:0]     = blinkMask_q;
            if (isStatus) begin
                prdata[0]             = phase_q;
                prdata[8 +: PWM_BITS] = pwmCnt_q;
            end
            for (int i = 0; i < NUM_CH; i++) begin
                if (dutySel[i]) prdata[PWM_BITS-1:0] = duty_q[i];
            end
        end
    end

    // The >= compares let a smaller PRESCALE or BLINK_PERIOD act at once without wrapping.
    always_comb begin
        prescCnt_d = prescCnt_q;
        pwmCnt_d   = pwmCnt_q;
        blinkCnt_d = blinkCnt_q;
        phase_d    = phase_q;
        if (!en) begin
            prescCnt_d = '0;
            pwmCnt_d   = '0;
            blinkCnt_d = '0;
            phase_d    = 1'b1;
        end else begin
            prescCnt_d = tick ? '0 : prescCnt_q + 1'b1;
            if (tick) begin
                pwmCnt_d = wrap ? '0 : pwmCnt_q + 1'b1;
            end
            if (wrap) begin
                if (blinkCnt_q >= blinkPer_q) begin
                    blinkCnt_d = '0;
                    phase_d    = ~phase_q;
                end else begin
                    blinkCnt_d = blinkCnt_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            prescCnt_q <= '0;
            pwmCnt_q   <= '0;
            blinkCnt_q <= '0;
            phase_q    <= 1'b1;
        end else begin
            prescCnt_q <= prescCnt_d;
            pwmCnt_q   <= pwmCnt_d;
            blinkCnt_q <= blinkCnt_d;
            phase_q    <= phase_d;
        end
    end

    // A DUTY write landing on the wrap edge is forwarded so the shadow still catches it.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
        assign dutySel[i]  = isDuty & (dutyRel[31:2] == 30'(i));
        assign dutyNext[i] = (wrOk & dutySel[i]) ? pwdata[PWM_BITS-1:0] : duty_q[i];

        led_pwm_chan #(
            .PWM_BITS(PWM_BITS)
        ) u_chan (
            .clk      (clk),
            .rst      (rst),
            .load_i   (wrap | ~en),
            .en_i     (en),
            .blank_i  (blinkEn & blinkMask_q[i] & ~phase_q),
            .duty_i   (dutyNext[i]),
            .pwm_cnt_i(pwmCnt_q),
            .led_o    (led_out[i])
        );
    end

endmodule

// File: tb/tb_apb_pwm_led_ctl.sv
// Scoreboard bench for apb_pwm_led_ctl: expectations are queued as stimulus is
// issued and popped when the corresponding DUT response is sampled.
module tb_apb_pwm_led_ctl;
    import apb_led_pkg::*;

    localparam int NUM_CH   = 14;
    localparam int PWM_BITS = 8;

    typedef struct {
        string       name;
        logic [31:0] value;
    } expItem_t;

    logic              clk;
    logic              rst;
    logic [31:0]       paddr;
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [31:0]       pwdata;
    logic [31:0]       prdata;
    logic              pready;
    logic              pslverr;
    logic [NUM_CH-1:0] led_out;

    expItem_t scoreboard[$];
    int       testsRun;
    int       testsFailed;

    apb_pwm_led_ctl #(
        .NUM_CH(NUM_CH), .PWM_BITS(PWM_BITS), .PRESC_BITS(16), .ADDR_W(8)
    ) dut (
        .clk(clk), .rst(rst), .paddr(paddr), .psel(psel), .penable(penable),
        .pwrite(pwrite), .pwdata(pwdata), .prdata(prdata), .pready(pready),
        .pslverr(pslverr), .led_out(led_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] timeout");
    end

    // Each transfer: setup at a negedge, access at the next, commit at the following posedge.
    task automatic apb_write(input logic [31:0] addr, input logic [31:0] data, output logic err);
        @(negedge clk);
        paddr = addr; pwdata = data; pwrite = 1'b1; psel = 1'b1; penable = 1'b0;
        @(negedge clk);
        penable = 1'b1;
        #1 err = pslverr;
        @(posedge clk);
        #1 psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic apb_read(input logic [31:0] addr, output logic [31:0] data, output logic err);
        @(negedge clk);
        paddr = addr; pwrite = 1'b0; psel = 1'b1; penable = 1'b0;
        @(negedge clk);
        penable = 1'b1;
        #1 data = prdata; err = pslverr;
        @(posedge clk);
        #1 psel = 1'b0; penable = 1'b0;
    endtask

    task automatic test_regs_cleared(input string tag);
        logic [31:0] addrs [7];
        logic [31:0] exps [7];
        logic [31:0] data;
        logic        err;
        expItem_t    item;
        addrs = '{CTRL_OFS, PRESCALE_OFS, BLINK_PER_OFS, BLINK_MASK_OFS, STATUS_OFS,
                  DUTY_BASE, DUTY_BASE + 32'(4 * (NUM_CH - 1))};
        exps  = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h1, 32'h0, 32'h0};
        for (int i = 0; i < 7; i++) begin
            scoreboard.push_back('{$sformatf("%s read 0x%0h", tag, addrs[i]), exps[i]});
            scoreboard.push_back('{$sformatf("%s pslverr 0x%0h", tag, addrs[i]), 32'h0});
            apb_read(addrs[i], data, err);
            item = scoreboard.pop_front();
            testsRun++;
            if (data !== item.value) begin
                testsFailed++;
                $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", item.name, data, item.value);
            end
            item = scoreboard.pop_front();
            testsRun++;
            if (32'(err) !== item.value) begin
                testsFailed++;
                $display("[TB] FAIL %s: got %0d, expected %0d", item.name, err, item.value);
            end
        end
    endtask

    task automatic test_reset();
        expItem_t item;
        rst = 1'b0;
        scoreboard.push_back('{"reset led_out", 32'h0});
        scoreboard.push_back('{"reset pslverr", 32'h0});
        scoreboard.push_back('{"pready tied", 32'h1});
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        item = scoreboard.pop_front();
        testsRun++;
        if (32'(led_out) !== item.value) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", item.name, led_out, item.value);
        end
        item = scoreboard.pop_front();
        testsRun++;
        if (32'(pslverr) !== item.value) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", item.name, pslverr, item.value);
        end
        item = scoreboard.pop_front();
        testsRun++;
        if (32'(pready) !== item.value) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", item.name, pready, item.value);
        end
        test_regs_cleared("reset");
    endtask

    task automatic test_basic_pwm();
        logic     err;
        int       c0, c1, others;
        expItem_t item;
        apb_write(PRESCALE_OFS, 32'd0, err);
        apb_write(DUTY_BASE, 32'd64, err);
        apb_write(DUTY_BASE + 32'd4, 32'd255, err);
        scoreboard.push_back('{"basic led at enable edge", 32'h0});
        scoreboard.push_back('{"basic ch0 high cycles", 32'd64});
        scoreboard.push_back('{"basic ch1 high cycles", 32'd255});
        scoreboard.push_back('{"basic other channels high cycles", 32'd0});
        apb_write(CTRL_OFS, 32'h1, err);
        @(negedge clk);
        item = scoreboard.pop_front();
        testsRun++;
        if (32'(led_out) !== item.value) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", item.name, led_out, item.value);
        end
        c0 = 0; c1 = 0; others = 0;
        for (int k = 0; k < 255; k++) begin
            @(negedge clk);
            c0 += int'(led_out[0]);
            c1 += int'(led_out[1]);
            if ((led_out >> 2) != '0) others++;
        end
        item = scoreboard.pop_front();
        testsRun++;
        if (32'(c0) !== item.value) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", item.name, c0, item.value);
        end
        item = scoreboard.pop_front();
        testsRun++;
        if (32'(c1) !== item.value) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", item.name, c1, item.value);
        end
        item = scoreboard.pop_front();
        testsRun++;
        if (32'(others) !== item.value) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", item.name, others, item.value);
        end
    endtask

    task automatic test_glitch_free();
        logic     prev, found, err;
        int       hi0, hi1;
        expItem_t item;
        found = 1'b0;
        @(negedge clk);
        prev = led_out[0];
        for (int n = 0; n < 600 && !found; n++) begin
            @(negedge clk);
            if (led_out[0] && !prev) found = 1'b1;
            prev = led_out[0];
        end
        if (!found) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL glitch period start: got no ch0 rising edge in 600 cycles, expected one");
            return;
        end
        scoreboard.push_back('{"glitch current-period high cycles", 32'd64});
        scoreboard.push_back('{"glitch next-period high cycles", 32'd128});
        hi0 = 1; hi1 = 0;
        fork
            begin
                for (int k = 1; k < 510; k++) begin
                    @(negedge clk);
                    if (k < 255) hi0 += int'(led_out[0]);
                    else         hi1 += int'(led_out[0]);
                end
            end
            begin
                repeat (7) @(negedge clk);
                apb_write(DUTY_BASE, 32'd128, err);
            end
        join
        item = scoreboard.pop_front();
        testsRun++;
        if (32'(hi0) !== item.value) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", item.name, hi0, item.value);
        end
        item = scoreboard.pop_front();
        testsRun++;
        if (32'(hi1) !== item.value) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", item.name, hi1, item.value);
        end
    endtask

    task automatic test_blink();
        logic     err;
        int       onCnt, offCnt, ch1Cnt;
        expItem_t item;
        apb_write(CTRL_OFS, 32'h0, err);
        apb_write(DUTY_BASE + 32'd8, 32'd255, err);
        apb_write(BLINK_PER_OFS, 32'd1, err);
        apb_write(BLINK_MASK_OFS, 32'h4, err);
        scoreboard.push_back('{"blink ch2 on-phase cycles", 32'd510});
        scoreboard.push_back('{"blink ch2 off-phase cycles", 32'd0});
        scoreboard.push_back('{"blink ch2 relit", 32'd1});
        scoreboard.push_back('{"blink ch1 unmasked cycles", 32'd1020});
        apb_write(CTRL_OFS, 32'h3, err);
        @(negedge clk);
        onCnt = 0; offCnt = 0; ch1Cnt = 0;
        for (int k = 1; k <= 1020; k++) begin
            @(negedge clk);
            if (k <= 510) onCnt  += int'(led_out[2]);
            else          offCnt += int'(led_out[2]);
            ch1Cnt += int'(led_out[1]);
        end
        item = scoreboard.pop_front();
        testsRun++;
        if (32'(onCnt) !== item.value) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", item.name, onCnt, item.value);
        end
        item = scoreboard.pop_front();
        testsRun++;
        if (32'(offCnt) !== item.value) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", item.name, offCnt, item.value);
        end
        @(negedge clk);
        item = scoreboard.pop_front();
        testsRun++;
        if (32'(led_out[2]) !== item.value) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", item.name, led_out[2], item.value);
        end
        item = scoreboard.pop_front();
        testsRun++;
        if (32'(ch1Cnt) !== item.value) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", item.name, ch1Cnt, item.value);
        end
    endtask

    task automatic test_errors();
        logic [31:0] addrs [8];
        logic [31:0] wdata [8];
        logic        isWr [8];
        logic [31:0] expData [8];
        logic        expErr [8];
        logic [31:0] data;
        logic        err;
        expItem_t    item;
        apb_write(CTRL_OFS, 32'h0, err);
        addrs   = '{DUTY_BASE + 32'(4 * (NUM_CH - 1)), 32'h1C, STATUS_OFS, STATUS_OFS,
                    DUTY_BASE + 32'(4 * NUM_CH), DUTY_BASE + 32'(4 * NUM_CH),
                    DUTY_BASE + 32'(4 * (NUM_CH - 1)), DUTY_BASE};
        wdata   = '{32'h33, 32'h0, 32'hFFFF_FFFF, 32'h0, 32'hAA, 32'h0, 32'h0, 32'h0};
        isWr    = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        expData = '{32'h0, 32'h0, 32'h0, 32'h1, 32'h0, 32'h0, 32'h33, 32'd128};
        expErr  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 8; i++) begin
            scoreboard.push_back('{$sformatf("err pslverr %s 0x%0h", isWr[i] ? "wr" : "rd", addrs[i]),
                                   32'(expErr[i])});
            if (isWr[i]) begin
                apb_write(addrs[i], wdata[i], err);
            end else begin
                scoreboard.push_back('{$sformatf("err read data 0x%0h", addrs[i]), expData[i]});
                apb_read(addrs[i], data, err);
            end
            item = scoreboard.pop_front();
            testsRun++;
            if (32'(err) !== item.value) begin
                testsFailed++;
                $display("[TB] FAIL %s: got %0d, expected %0d", item.name, err, item.value);
            end
            if (!isWr[i]) begin
                item = scoreboard.pop_front();
                testsRun++;
                if (data !== item.value) begin
                    testsFailed++;
                    $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", item.name, data, item.value);
                end
            end
        end
    endtask

    task automatic test_disable();
        logic [31:0] data;
        logic        err;
        expItem_t    item;
        apb_write(DUTY_BASE, 32'd200, err);
        scoreboard.push_back('{"disable STATUS one cycle after enable", 32'h101});
        scoreboard.push_back('{"disable led on commit edge", 32'h7});
        scoreboard.push_back('{"disable led after commit", 32'h0});
        scoreboard.push_back('{"disable STATUS after commit", 32'h1});
        apb_write(CTRL_OFS, 32'h1, err);
        apb_read(STATUS_OFS, data, err);
        item = scoreboard.pop_front();
        testsRun++;
        if (data !== item.value) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", item.name, data, item.value);
        end
        repeat (97) @(negedge clk);
        apb_write(CTRL_OFS, 32'h0, err);
        item = scoreboard.pop_front();
        testsRun++;
        if (32'(led_out) !== item.value) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", item.name, led_out, item.value);
        end
        @(posedge clk);
        #1;
        item = scoreboard.pop_front();
        testsRun++;
        if (32'(led_out) !== item.value) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", item.name, led_out, item.value);
        end
        apb_read(STATUS_OFS, data, err);
        item = scoreboard.pop_front();
        testsRun++;
        if (data !== item.value) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", item.name, data, item.value);
        end
    endtask

    task automatic test_reset_mid();
        logic     err;
        expItem_t item;
        scoreboard.push_back('{"reset-mid led before reset", 32'h7});
        scoreboard.push_back('{"reset-mid led at reset edge", 32'h0});
        apb_write(CTRL_OFS, 32'h1, err);
        repeat (101) @(negedge clk);
        item = scoreboard.pop_front();
        testsRun++;
        if (32'(led_out) !== item.value) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", item.name, led_out, item.value);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        item = scoreboard.pop_front();
        testsRun++;
        if (32'(led_out) !== item.value) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", item.name, led_out, item.value);
        end
        rst = 1'b1;
        test_regs_cleared("reset-mid");
    endtask

    task automatic test_prescale();
        logic [31:0] data;
        logic        err;
        expItem_t    item;
        apb_write(PRESCALE_OFS, 32'd2, err);
        scoreboard.push_back('{"prescale STATUS at cycle 1", 32'h001});
        scoreboard.push_back('{"prescale STATUS at cycle 3", 32'h101});
        scoreboard.push_back('{"prescale STATUS at cycle 15", 32'h501});
        apb_write(CTRL_OFS, 32'h1, err);
        for (int r = 0; r < 3; r++) begin
            if (r == 2) repeat (10) @(negedge clk);
            apb_read(STATUS_OFS, data, err);
            item = scoreboard.pop_front();
            testsRun++;
            if (data !== item.value) begin
                testsFailed++;
                $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", item.name, data, item.value);
            end
        end
    endtask

    initial begin
        rst = 1'b0; paddr = '0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; pwdata = '0;
        testsRun = 0;
        testsFailed = 0;
        test_reset();
        test_basic_pwm();
        test_glitch_free();
        test_blink();
        test_errors();
        test_disable();
        test_reset_mid();
        test_prescale();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
